// File: rtl/jtag_host_ctrl.sv
// jtag_host_ctrl: JTAG initiator driving TCK/TMS/TDI from a system-clock
// command interface. It tracks the target TAP (TLR or RTI), generates the
// navigation headers and trailers itself, and returns captured TDO as one
// response per command.
module jtag_host_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned MAX_LEN = 64,
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               ntrst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [LEN_W-1:0]   cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               rsp_err_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  // Bit index covers header (<=6) + payload (<2^LEN_W) + trailer (2).
  localparam int unsigned IDX_W = LEN_W + 2;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PRE_W = 6;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SHIFT,
    ST_POST,
    ST_RSP
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic                 r_first,     w_first_nxt;
  logic [LEN_W-1:0]     r_len,       w_len_nxt;
  logic [MAX_LEN-1:0]   r_data,      w_data_nxt;
  logic [PRE_W-1:0]     r_pre_tms,   w_pre_tms_nxt;
  logic [2:0]           r_pre_cnt,   w_pre_cnt_nxt;
  logic                 r_idle,      w_idle_nxt;
  logic                 r_err,       w_err_nxt;
  logic [IDX_W-1:0]     r_total,     w_total_nxt;
  logic [IDX_W-1:0]     r_bit,       w_bit_nxt;
  logic [DIV_W-1:0]     r_div,       w_div_nxt;
  logic                 r_tck,       w_tck_nxt;
  logic                 r_tms,       w_tms_nxt;
  logic                 r_tdi,       w_tdi_nxt;
  logic [MAX_LEN-1:0]   r_cap,       w_cap_nxt;
  logic                 r_tlr,       w_tlr_nxt;
  logic                 r_cmd_ready, w_cmd_ready_nxt;
  logic                 r_rsp_valid, w_rsp_valid_nxt;
  logic [MAX_LEN-1:0]   r_rsp_data,  w_rsp_data_nxt;
  logic                 r_rsp_err,   w_rsp_err_nxt;

  // Command decode
  logic                 w_len_bad;
  logic [PRE_W-1:0]     w_dec_pre_tms;
  logic [2:0]           w_dec_pre_cnt;
  logic [LEN_W-1:0]     w_dec_len;
  logic [1:0]           w_dec_post_cnt;
  logic                 w_dec_idle;
  logic                 w_dec_err;
  logic [IDX_W-1:0]     w_dec_total;

  // Next-bit presentation
  logic [IDX_W-1:0]     w_pidx;
  logic [IDX_W-1:0]     w_pre_ext;
  logic [IDX_W-1:0]     w_len_ext;
  logic [IDX_W-1:0]     w_pj;
  logic [IDX_W-1:0]     w_cj;
  logic                 w_pre_bit;
  logic                 w_data_bit;
  logic                 w_p_tms;
  logic                 w_p_tdi;
  state_t               w_p_state;
  logic [MAX_LEN-1:0]   w_cap_set;
  logic                 w_div_end;
  logic                 w_last_bit;

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;
  assign tck_o       = r_tck;
  assign tms_o       = r_tms;
  assign tdi_o       = r_tdi;

  assign w_len_bad   = (cmd_len_i == '0) || (cmd_len_i > LEN_W'(MAX_LEN));
  assign w_dec_total = IDX_W'(w_dec_pre_cnt) + IDX_W'(w_dec_len) + IDX_W'(w_dec_post_cnt);

  // Translate an incoming command into header bits, payload length and trailer length.
  always_comb begin
    w_dec_pre_tms  = '0;
    w_dec_pre_cnt  = '0;
    w_dec_len      = '0;
    w_dec_post_cnt = '0;
    w_dec_idle     = 1'b0;
    w_dec_err      = 1'b0;
    case (cmd_op_i)
      OP_RESET: begin
        // TMS 1,1,1,1,1,0 (LSB first)
        w_dec_pre_tms = 6'b011111;
        w_dec_pre_cnt = 3'd6;
      end
      OP_IR: begin
        if (w_len_bad) begin
          w_dec_err = 1'b1;
        end else begin
          // optional TLR->RTI 0, then 1,1,0,0
          w_dec_pre_tms  = r_tlr ? 6'b000110 : 6'b000011;
          w_dec_pre_cnt  = r_tlr ? 3'd5 : 3'd4;
          w_dec_len      = cmd_len_i;
          w_dec_post_cnt = 2'd2;
        end
      end
      OP_DR: begin
        if (w_len_bad) begin
          w_dec_err = 1'b1;
        end else begin
          // optional TLR->RTI 0, then 1,0,0
          w_dec_pre_tms  = r_tlr ? 6'b000010 : 6'b000001;
          w_dec_pre_cnt  = r_tlr ? 3'd4 : 3'd3;
          w_dec_len      = cmd_len_i;
          w_dec_post_cnt = 2'd2;
        end
      end
      OP_IDLE: begin
        // a zero-length idle produces no TCK at all, so no TLR prefix either
        w_dec_idle    = 1'b1;
        w_dec_len     = cmd_len_i;
        w_dec_pre_cnt = (r_tlr && (cmd_len_i != '0)) ? 3'd1 : 3'd0;
      end
      default: begin
        w_dec_idle = 1'b1;
      end
    endcase
  end

  assign w_pidx     = r_first ? '0 : (r_bit + IDX_W'(1));
  assign w_pre_ext  = IDX_W'(r_pre_cnt);
  assign w_len_ext  = IDX_W'(r_len);
  assign w_pj       = w_pidx - w_pre_ext;
  assign w_cj       = r_bit - w_pre_ext;
  assign w_pre_bit  = |(r_pre_tms & (PRE_W'(1) << w_pidx));
  assign w_data_bit = |(r_data & ({{(MAX_LEN-1){1'b0}}, 1'b1} << w_pj));
  assign w_cap_set  = r_cap | ({{(MAX_LEN-1){1'b0}}, tdo_i} << w_cj);
  assign w_div_end  = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last_bit = (r_bit == (r_total - IDX_W'(1)));

  // TMS/TDI and section for the bit about to be presented.
  always_comb begin
    w_p_state = ST_POST;
    w_p_tms   = 1'b0;
    w_p_tdi   = 1'b0;
    if (w_pidx < w_pre_ext) begin
      w_p_state = ST_PRE;
      w_p_tms   = w_pre_bit;
    end else if (w_pj < w_len_ext) begin
      w_p_state = ST_SHIFT;
      w_p_tms   = !r_idle && (w_pj == (w_len_ext - IDX_W'(1)));
      w_p_tdi   = !r_idle && w_data_bit;
    end else begin
      // trailer 1,0: Exit1 -> Update -> RTI
      w_p_tms   = (w_pj == w_len_ext);
    end
  end

  // Next-state and output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_first_nxt     = r_first;
    w_len_nxt       = r_len;
    w_data_nxt      = r_data;
    w_pre_tms_nxt   = r_pre_tms;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_idle_nxt      = r_idle;
    w_err_nxt       = r_err;
    w_total_nxt     = r_total;
    w_bit_nxt       = r_bit;
    w_div_nxt       = r_div;
    w_tck_nxt       = r_tck;
    w_tms_nxt       = r_tms;
    w_tdi_nxt       = r_tdi;
    w_cap_nxt       = r_cap;
    w_tlr_nxt       = r_tlr;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i && r_cmd_ready) begin
          w_state_nxt   = ST_PRE;
          w_first_nxt   = 1'b1;
          w_len_nxt     = w_dec_len;
          w_data_nxt    = cmd_data_i;
          w_pre_tms_nxt = w_dec_pre_tms;
          w_pre_cnt_nxt = w_dec_pre_cnt;
          w_idle_nxt    = w_dec_idle;
          w_err_nxt     = w_dec_err;
          w_total_nxt   = w_dec_total;
          w_bit_nxt     = '0;
          w_div_nxt     = '0;
          w_cap_nxt     = '0;
        end
      end

      ST_PRE, ST_SHIFT, ST_POST: begin
        if (r_first) begin
          // launch edge: present bit 0, or answer at once when there is nothing to clock
          w_first_nxt = 1'b0;
          if (r_total == '0) begin
            w_state_nxt     = ST_RSP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = r_cap;
            w_rsp_err_nxt   = r_err;
          end else begin
            w_state_nxt = w_p_state;
            w_bit_nxt   = w_pidx;
            w_tms_nxt   = w_p_tms;
            w_tdi_nxt   = w_p_tdi;
            w_div_nxt   = '0;
          end
        end else if (w_div_end) begin
          w_div_nxt = '0;
          if (!r_tck) begin
            // rising TCK: sample TDO as seen just before the target's edge
            w_tck_nxt = 1'b1;
            if ((r_state == ST_SHIFT) && !r_idle) begin
              w_cap_nxt = w_cap_set;
            end
          end else begin
            w_tck_nxt = 1'b0;
            if (w_last_bit) begin
              w_state_nxt     = ST_RSP;
              w_rsp_valid_nxt = 1'b1;
              w_rsp_data_nxt  = r_cap;
              w_rsp_err_nxt   = 1'b0;
              w_tlr_nxt       = 1'b0;
            end else begin
              w_state_nxt = w_p_state;
              w_bit_nxt   = w_pidx;
              w_tms_nxt   = w_p_tms;
              w_tdi_nxt   = w_p_tdi;
            end
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end

      ST_RSP: begin
        if (rsp_ready_i) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge ntrst_i) begin
    if (!ntrst_i) begin
      r_state     <= ST_IDLE;
      r_first     <= 1'b0;
      r_len       <= '0;
      r_data      <= '0;
      r_pre_tms   <= '0;
      r_pre_cnt   <= '0;
      r_idle      <= 1'b0;
      r_err       <= 1'b0;
      r_total     <= '0;
      r_bit       <= '0;
      r_div       <= '0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_cap       <= '0;
      r_tlr       <= 1'b1;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_first     <= w_first_nxt;
      r_len       <= w_len_nxt;
      r_data      <= w_data_nxt;
      r_pre_tms   <= w_pre_tms_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_idle      <= w_idle_nxt;
      r_err       <= w_err_nxt;
      r_total     <= w_total_nxt;
      r_bit       <= w_bit_nxt;
      r_div       <= w_div_nxt;
      r_tck       <= w_tck_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi       <= w_tdi_nxt;
      r_cap       <= w_cap_nxt;
      r_tlr       <= w_tlr_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_jtag_host_ctrl.sv
// Bench for jtag_host_ctrl: a behavioural TAP (IDCODE + BYPASS) on the link,
// directed commands pushed to a scoreboard, and a negedge monitor that
// checks responses, TCK/TMS counts, TCK period, stall and reset behaviour.
`timescale 1ns/1ps
module tb_jtag_host_ctrl;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned MAX_LEN = 64;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [31:0] IDCODE    = 32'h1DEAD3FF;
  localparam logic [4:0]  IR_IDCODE = 5'b00001;
  localparam logic [1:0]  OP_RESET = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_IDLE = 2'b11;

  logic               clk_i = 1'b0;
  logic               ntrst_i = 1'b0;
  logic               cmd_valid_i = 1'b0;
  logic               cmd_ready_o;
  logic [1:0]         cmd_op_i = '0;
  logic [LEN_W-1:0]   cmd_len_i = '0;
  logic [MAX_LEN-1:0] cmd_data_i = '0;
  logic               rsp_valid_o;
  logic               rsp_ready_i = 1'b1;
  logic [MAX_LEN-1:0] rsp_data_o;
  logic               rsp_err_o;
  logic               tck_o, tms_o, tdi_o;
  logic               tdo_i;

  always #5 clk_i = ~clk_i;

  jtag_host_ctrl #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk_i       (clk_i),
    .ntrst_i     (ntrst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_data_i  (cmd_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .tck_o       (tck_o),
    .tms_o       (tms_o),
    .tdi_o       (tdi_o),
    .tdo_i       (tdo_i)
  );

  // ---------------- TAP target model ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPDIR
  } tap_t;

  tap_t        ts;
  logic [4:0]  ir, irsh;
  logic [31:0] dr;
  logic        tdo_r;
  assign tdo_i = tdo_r;

  function automatic tap_t tap_next(input tap_t s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR   : T_RTI;
      T_RTI:   return m ? T_SELDR : T_RTI;
      T_SELDR: return m ? T_SELIR : T_CAPDR;
      T_CAPDR: return m ? T_EX1DR : T_SHDR;
      T_SHDR:  return m ? T_EX1DR : T_SHDR;
      T_EX1DR: return m ? T_UPDDR : T_PAUDR;
      T_PAUDR: return m ? T_EX2DR : T_PAUDR;
      T_EX2DR: return m ? T_UPDDR : T_SHDR;
      T_UPDDR: return m ? T_SELDR : T_RTI;
      T_SELIR: return m ? T_TLR   : T_CAPIR;
      T_CAPIR: return m ? T_EX1IR : T_SHIR;
      T_SHIR:  return m ? T_EX1IR : T_SHIR;
      T_EX1IR: return m ? T_UPDIR : T_PAUIR;
      T_PAUIR: return m ? T_EX2IR : T_PAUIR;
      T_EX2IR: return m ? T_UPDIR : T_SHIR;
      default: return m ? T_SELDR : T_RTI;
    endcase
  endfunction

  always @(posedge tck_o or negedge ntrst_i) begin
    if (!ntrst_i) begin
      ts <= T_TLR; ir <= IR_IDCODE; irsh <= '0; dr <= '0;
    end else begin
      case (ts)
        T_TLR:   ir   <= IR_IDCODE;
        T_CAPDR: dr   <= (ir == IR_IDCODE) ? IDCODE : 32'h0;
        T_SHDR:  dr   <= (ir == IR_IDCODE) ? {tdi_o, dr[31:1]} : {31'h0, tdi_o};
        T_CAPIR: irsh <= 5'b00001;
        T_SHIR:  irsh <= {tdi_o, irsh[4:1]};
        T_UPDIR: ir   <= irsh;
        default: ;
      endcase
      ts <= tap_next(ts, tms_o);
    end
  end

  always @(negedge tck_o or negedge ntrst_i) begin
    if (!ntrst_i) tdo_r <= 1'b0;
    else          tdo_r <= (ts == T_SHDR) ? dr[0] : ((ts == T_SHIR) ? irsh[0] : 1'b0);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [MAX_LEN-1:0] data;
    logic               err;
    int                 tcks;
    int                 tmshi;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_tck = 1'b0;
  int   tck_cnt = 0, tmshi_cnt = 0, cyc = 0, last_rise = 0;
  exp_t e;

  always @(negedge clk_i) begin
    cyc++;
    if (!ntrst_i) begin
      chk("rst_tck",       64'(tck_o),       64'd0);
      chk("rst_tms",       64'(tms_o),       64'd1);
      chk("rst_tdi",       64'(tdi_o),       64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_rsp_data",  64'(rsp_data_o),  64'd0);
      chk("rst_rsp_err",   64'(rsp_err_o),   64'd0);
      tck_cnt = 0; tmshi_cnt = 0; prev_tck = 1'b0;
    end else begin
      if (tck_o && !prev_tck) begin
        tck_cnt++;
        if (tms_o) tmshi_cnt++;
        if (tck_cnt > 1) chk("tck_period", 64'(cyc - last_rise), 64'(2 * CLK_DIV));
        last_rise = cyc;
      end
      prev_tck = tck_o;
      if (rsp_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
        end else if (rsp_ready_i) begin
          e = q.pop_front();
          chk("rsp_data",  64'(rsp_data_o), 64'(e.data));
          chk("rsp_err",   64'(rsp_err_o),  64'(e.err));
          chk("tck_count", 64'(tck_cnt),    64'(e.tcks));
          chk("tms_high",  64'(tmshi_cnt),  64'(e.tmshi));
          tck_cnt = 0; tmshi_cnt = 0;
        end else begin
          chk("stall_data",  64'(rsp_data_o),  64'(q[0].data));
          chk("stall_err",   64'(rsp_err_o),   64'(q[0].err));
          chk("stall_ready", 64'(cmd_ready_o), 64'd0);
          chk("stall_tck",   64'(tck_o),       64'd0);
        end
      end
    end
    if (done) begin
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input int unsigned len, input logic [MAX_LEN-1:0] data,
                       input logic [MAX_LEN-1:0] ed, input logic ee, input int et, input int eh,
                       input bit track);
    exp_t x;
    int   n;
    if (track) begin
      x.data = ed; x.err = ee; x.tcks = et; x.tmshi = eh;
      q.push_back(x);
    end
    cmd_op_i    = op;
    cmd_len_i   = LEN_W'(len);
    cmd_data_i  = data;
    cmd_valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (cmd_ready_o) break;
      n++;
      if (n > 2000) begin
        $display("FAIL cmd_accept: no ready after %0d cycles", n);
        $fatal(1, "command accept timeout");
      end
    end
    @(posedge clk_i);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(posedge clk_i);
      if (q.size() == 0) break;
      n++;
      if (n > 5000) begin
        $display("FAIL rsp_wait: %0d responses outstanding after %0d cycles", q.size(), n);
        $fatal(1, "response timeout");
      end
    end
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_i);
    #1 ntrst_i = 1'b1;
    @(posedge clk_i); #1;

    // IDCODE from TLR: 1 prefix + 3 header + 32 + 2 trailer
    issue(OP_DR, 32, '0, 64'(IDCODE), 1'b0, 38, 3, 1'b1); wait_done();
    issue(OP_RESET, 0, '0, '0, 1'b0, 6, 5, 1'b1); wait_done();
    issue(OP_IR, 5, 64'h1F, 64'h01, 1'b0, 11, 4, 1'b1); wait_done();
    issue(OP_DR, 4, 64'hA, 64'h4, 1'b0, 9, 3, 1'b1); wait_done();
    issue(OP_IDLE, 3, 64'hFFFF, '0, 1'b0, 3, 0, 1'b1); wait_done();
    issue(OP_IDLE, 0, '0, '0, 1'b0, 0, 0, 1'b1); wait_done();
    issue(OP_DR, 0, 64'hFF, '0, 1'b1, 0, 0, 1'b1); wait_done();
    issue(OP_DR, MAX_LEN + 1, 64'hFF, '0, 1'b1, 0, 0, 1'b1); wait_done();
    issue(OP_IR, 5, 64'(IR_IDCODE), 64'h01, 1'b0, 11, 4, 1'b1); wait_done();
    issue(OP_DR, 32, '0, 64'(IDCODE), 1'b0, 37, 3, 1'b1); wait_done();
    // full-width scan: IDCODE comes out first, then the first 32 TDI bits
    issue(OP_DR, 64, 64'h12345678_CAFEF00D, {32'hCAFEF00D, IDCODE}, 1'b0, 69, 3, 1'b1); wait_done();

    // response backpressure for 20 clocks
    rsp_ready_i = 1'b0;
    issue(OP_DR, 32, '0, 64'(IDCODE), 1'b0, 37, 3, 1'b1);
    n = 0;
    while (!rsp_valid_o) begin
      @(posedge clk_i);
      n++;
      if (n > 2000) begin
        $display("FAIL rsp_valid_wait: no response after %0d cycles", n);
        $fatal(1, "response timeout");
      end
    end
    repeat (20) @(posedge clk_i);
    #1 rsp_ready_i = 1'b1;
    wait_done();

    // reset in the middle of a DR shift: no response, tracked state back to TLR
    issue(OP_DR, 32, '0, '0, 1'b0, 0, 0, 1'b0);
    repeat (30) @(posedge clk_i);
    #2 ntrst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 ntrst_i = 1'b1;
    @(posedge clk_i); #1;
    issue(OP_DR, 32, '0, 64'(IDCODE), 1'b0, 38, 3, 1'b1); wait_done();

    repeat (5) @(posedge clk_i);
    done = 1'b1;
  end

endmodule

// File: doc/jtag_host_ctrl.md
# jtag_host_ctrl

JTAG host (initiator) controller: the driving end of the IEEE 1149.1 link, used to exercise TAP targets and the cJTAG bridge from a system-clock command interface. Accepts reset, idle, IR-scan and DR-scan commands. Generates TCK, TMS and TDI, samples TDO, and returns the captured bits as one response per command. It tracks the target TAP state internally and emits the standard TMS navigation sequences itself.

## Interface
- CLK_DIV, 2: clk_i cycles per TCK half-period; legal range ≥1.
- MAX_LEN, 64: maximum scan length in bits. LEN_W = $clog2(MAX_LEN+1) is a localparam.
- clk_i  in  1  system clock; all outputs are registered on its rising edge.
- ntrst_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted on a clk_i edge where valid && ready.
- cmd_op_i  in  2  00 RESET, 01 IR scan, 10 DR scan, 11 IDLE.
- cmd_len_i  in  LEN_W  scan length in bits, or idle TCK count.
- cmd_data_i  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed on a clk_i edge where valid && ready.
- rsp_data_o  out  MAX_LEN  captured TDO: bit i is the TDO sampled during shift bit i; bits ≥ len are 0.
- rsp_err_o  out  1  illegal length; no TCK pulses were generated.
- tck_o  out  1  JTAG clock.
- tms_o  out  1  JTAG mode select.
- tdi_o  out  1  JTAG data out to target.
- tdo_i  in  1  JTAG data from target.

## Operation
- FSM states:
  - IDLE: cmd_ready_o=1 only here, and only while rsp_valid_o=0.
  - PRE: header TMS bits.
  - SHIFT: data bits.
  - POST: trailer TMS bits.
  - RSP: holds the response until rsp_ready_i.
- Tracked target state is TLR or RTI. After reset it is TLR.
- RESET: 5 TCKs with TMS=1, then 1 TCK with TMS=0. Ends in RTI. 6 TCKs total.
- Any IR scan, DR scan or IDLE command issued while the tracked state is TLR is first prefixed by one TCK with TMS=0.
- IDLE: len TCKs with TMS=0. len=0 is legal: no TCK, immediate response.
- DR scan from RTI:
  - PRE TMS sequence 1,0,0.
  - SHIFT: len bits with TMS=0, except TMS=1 on the last bit.
  - POST TMS sequence 1,0.
  - Ends in RTI. Total len+5 TCKs.
- IR scan: PRE TMS sequence 1,1,0,0, then SHIFT and POST as for DR scan. Total len+6 TCKs.
- TDI is 0 outside SHIFT. In SHIFT, bit i drives cmd_data_i[i], latched at accept.
- Scan with len=0 or len>MAX_LEN: accepted, no TCK, response has rsp_err_o=1 and rsp_data_o=0. The tracked state is unchanged.
- Exactly one response per accepted command. RESET and IDLE return data 0, err 0.

## Timing
- Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0. FSM=IDLE, tracked state TLR.
- TCK phase: low for CLK_DIV clk cycles, then high for CLK_DIV clk cycles, so one TCK period = 2·CLK_DIV clk cycles.
- tms_o and tdi_o change only on the clk edge where tck_o goes low. The first bit is presented on the edge after accept, with tck_o low.
- tdo_i is sampled on the clk edge that drives tck_o 0→1, so it captures the value present before the target's rising edge.
- rsp_valid_o rises on the edge that returns tck_o low after the final rising edge. tck_o is idle low between commands, and tms_o holds the last driven value.
- Error responses: rsp_valid_o rises 1 clk after accept.
- Response backpressure: while rsp_valid_o=1 and rsp_ready_i=0, the response and all JTAG outputs hold, and cmd_ready_o=0.
- Reset asserted mid-operation: all outputs return to reset values immediately. The pending command and response are discarded, and the tracked state becomes TLR.

## Test plan
- Connect a TAP with IDCODE 32'h1DEAD3FF and CLK_DIV=2. After reset, issue a DR scan of len 32, data 0 → rsp_data 32'h1DEAD3FF, err 0, exactly 38 TCK rising edges (1 prefix + 37), TCK period of 4 clk.
- RESET, then IR scan of len 5, data 5'b11111 → rsp 5'b00001, 11 TCKs. Then DR scan of len 4, data 4'b1010 → rsp 4'b0100 (bypass).
- IDLE len 3 → exactly 3 TCKs with TMS=0 and rsp 0. IDLE len 0 → no TCK and rsp 0.
- DR scan len 0, and DR scan len MAX_LEN+1 → rsp_err=1, no TCK. A following IDCODE DR scan still returns 32'h1DEAD3FF.
- Hold rsp_ready_i=0 for 20 clk after a scan completes → rsp stable, cmd_ready_o=0, tck_o stays low. On release, the next command is accepted.
- Assert ntrst_i during SHIFT of a DR scan → outputs take reset values in the same cycle and no response is produced. The next DR scan returns IDCODE with 1 prefix TCK.
